// File: rtl/scrambler_pkg.sv
// Shared types and constants for the scrambler stage and its consumers.
// Holds index geometry, player states and the mode-to-count mapping.
package scrambler_pkg;

  localparam int IDX_W   = 3;
  localparam int NUM_IDX = 6;
  localparam int POS_W   = 3;

  typedef enum logic [1:0] {
    IDLE,
    SEND,
    GAP,
    FIN
  } player_state_t;

  localparam logic [POS_W-1:0] CNT_MODE0 = 3'd4;
  localparam logic [POS_W-1:0] CNT_MODE1 = 3'd5;
  localparam logic [POS_W-1:0] CNT_MODE2 = 3'd6;
  localparam logic [POS_W-1:0] CNT_MODE3 = 3'd6;

  function automatic logic [POS_W-1:0] mode_count(
    input logic [1:0] m
  );
    logic [POS_W-1:0] c;
    c = CNT_MODE3;
    case (m)
      2'b00:   c = CNT_MODE0;
      2'b01:   c = CNT_MODE1;
      2'b10:   c = CNT_MODE2;
      default: c = CNT_MODE3;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/rise_detect.sv
// Registered rising-edge detector: pulse is high while d is high
// and its previous-cycle copy is low.
module rise_detect (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic pulse
);

  logic d_q;

  always_ff @(posedge clk) begin
    if (rst) d_q <= 1'b0;
    else     d_q <= d;
  end

  assign pulse = d & ~d_q;

endmodule

// File: rtl/scramble_index_player.sv
// Captures six scramble indices on done and plays them out over valid/ready.
// Optional replay of the held sequence: SCRAMBLE_PLAYER_REPLAY_EN.
module scramble_index_player
  import scrambler_pkg::*;
#(
  parameter int GAP_CYCLES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             done,
  input  logic [1:0]       mode,
  input  logic [IDX_W-1:0] index1,
  input  logic [IDX_W-1:0] index2,
  input  logic [IDX_W-1:0] index3,
  input  logic [IDX_W-1:0] index4,
  input  logic [IDX_W-1:0] index5,
  input  logic [IDX_W-1:0] index6,
  input  logic             replay,
  input  logic             idx_ready,
  output logic [IDX_W-1:0] idx_out,
  output logic             idx_valid,
  output logic [POS_W-1:0] pos,
  output logic             busy,
  output logic             seq_done
);

  localparam int GAP_W =
    (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES + 1) : 1;
  localparam logic [GAP_W-1:0] GAP_INIT = GAP_W'(GAP_CYCLES);
  localparam logic [GAP_W-1:0] GAP_ONE  = GAP_W'(1);

  player_state_t state, state_n;

  logic [NUM_IDX-1:0][IDX_W-1:0] idx_buf;
  logic [POS_W-1:0] cnt;
  logic [POS_W-1:0] pos_q, pos_n;
  logic [GAP_W-1:0] gap, gap_n;
  logic [IDX_W-1:0] cur_idx;
  logic start, capture, restart_ok, xfer;

  rise_detect u_rise (
    .clk   (clk),
    .rst   (rst),
    .d     (done),
    .pulse (start)
  );

`ifdef SCRAMBLE_PLAYER_REPLAY_EN
  logic loaded;

  always_ff @(posedge clk) begin
    if (rst)          loaded <= 1'b0;
    else if (capture) loaded <= 1'b1;
  end

  assign restart_ok = replay & loaded;
`else
  logic unused_replay;
  assign unused_replay = replay;
  assign restart_ok    = 1'b0;
`endif

  assign idx_valid = (state == SEND);
  assign busy      = (state != IDLE);
  assign seq_done  = (state == FIN);
  assign pos       = pos_q;
  assign xfer      = idx_valid & idx_ready;

  always_comb begin
    cur_idx = '0;
    case (pos_q)
      3'd0:    cur_idx = idx_buf[0];
      3'd1:    cur_idx = idx_buf[1];
      3'd2:    cur_idx = idx_buf[2];
      3'd3:    cur_idx = idx_buf[3];
      3'd4:    cur_idx = idx_buf[4];
      3'd5:    cur_idx = idx_buf[5];
      default: cur_idx = '0;
    endcase
  end

  assign idx_out = idx_valid ? cur_idx : '0;

  always_comb begin
    state_n = state;
    pos_n   = pos_q;
    gap_n   = gap;
    capture = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          capture = 1'b1;
          state_n = SEND;
          pos_n   = '0;
        end else if (restart_ok) begin
          state_n = SEND;
          pos_n   = '0;
        end
      end
      SEND: begin
        if (xfer) begin
          if (pos_q == 3'(cnt - 3'd1)) begin
            state_n = FIN;
          end else begin
            pos_n = 3'(pos_q + 3'd1);
            if (GAP_CYCLES != 0) begin
              state_n = GAP;
              gap_n   = GAP_INIT;
            end
          end
        end
      end
      GAP: begin
        gap_n = GAP_W'(gap - GAP_ONE);
        if (gap == GAP_ONE) state_n = SEND;
      end
      FIN: state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      pos_q   <= '0;
      gap     <= '0;
      cnt     <= '0;
      idx_buf <= '0;
    end else begin
      state <= state_n;
      pos_q <= pos_n;
      gap   <= gap_n;
      if (capture) begin
        idx_buf <= {index6, index5, index4,
                    index3, index2, index1};
        cnt     <= mode_count(mode);
      end
    end
  end

endmodule

// File: doc/scramble_index_player.md
# scramble_index_player

Downstream consumer of the scrambler stage. Captures the six 3-bit scramble indices when the scrambler signals `done`, then plays them out one at a time over a valid/ready handshake, with a programmable idle gap between items. This lets the display or move-executor stage take one move per step. The number of indices played depends on the scramble `mode`.

## Interface
- `GAP_CYCLES`, default 4: idle cycles between consecutive items; 0 means back-to-back.
- `clk` in 1: single system clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `done` in 1: scrambler completion; a rising edge starts capture.
- `mode` in 2: scramble mode, sampled with the indices. Item count: 00→4, 01→5, 10→6, 11→6.
- `index1`..`index6` in 3 each: scrambler outputs, captured on start.
- `replay` in 1: restart playback of the held sequence (see Configuration).
- `idx_ready` in 1: consumer accepts `idx_out`.
- `idx_out` out 3: current index.
- `idx_valid` out 1: `idx_out` is valid.
- `pos` out 3: zero-based position of the current item.
- `busy` out 1: playback in progress.
- `seq_done` out 1: one-cycle pulse after the last item is accepted.

## Operation
- Edge detect: `start = done & ~done_q`, where `done_q` is a registered copy of `done` (reset 0).
- States:
  - IDLE: `busy`=0, `idx_valid`=0.
  - SEND: `idx_valid`=1, `idx_out`=buf[`pos`].
  - GAP: `idx_valid`=0, gap counter running.
  - FIN: `seq_done`=1.
- IDLE→SEND on `start`:
  - buf[0..5] ← `index1`..`index6`.
  - cnt ← count(`mode`).
  - `pos` ← 0.
  - `loaded` ← 1.
- SEND, on `idx_valid & idx_ready` (a transfer):
  - If `pos`==cnt−1: go to FIN.
  - Else `pos`++. Go to GAP with gap ← `GAP_CYCLES`, or stay in SEND if `GAP_CYCLES`==0.
- GAP: decrement gap each cycle; go to SEND when gap==1.
- FIN → IDLE unconditionally; `pos` is kept for observation.
- `busy` = 1 in SEND, GAP and FIN.
- `start` outside IDLE is ignored; buf is not overwritten mid-play.
- `idx_out` and `pos` are held stable while `idx_valid`=1 and `idx_ready`=0.
- The consumer may hold `idx_ready` high permanently.
- Mode 11 is treated as 6 items; no error flag.

## Timing
- Reset values: `idx_out`=0, `idx_valid`=0, `pos`=0, `busy`=0, `seq_done`=0. Internal: state=IDLE, buf=0, cnt=0, gap=0, `done_q`=0, `loaded`=0.
- `rst` overrides everything, including mid-playback. Nothing is emitted the cycle after reset.
- `done` sampled high at edge E (and low at E−1): `idx_valid`=1 from the cycle after E.
- With `idx_ready` tied high, the first transfer happens at edge E+1.
- Item spacing with ready high: `GAP_CYCLES`+1 cycles between transfers.
- Total sequence, ready high: N transfers. `seq_done` is high during the cycle after the last transfer, and `busy` drops the cycle after that.
- A `done` held high for many cycles is a single start. A new start needs `done` to go low and then high again.
- A `done` rising edge in the same cycle FIN→IDLE occurs is ignored. Start is evaluated only while state==IDLE.

## Configuration
- `SCRAMBLE_PLAYER_REPLAY_EN` defined:
  - In IDLE, `replay`=1 with `loaded`=1 → SEND with `pos`=0, reusing buf and cnt.
  - If `start` and `replay` are both high, `start` wins and new values are captured.
  - `replay` with `loaded`=0 is ignored.
- Not defined: the `replay` port is present but ignored, and `loaded` is not implemented.

## Structure
- Shared package `scrambler_pkg`:
  - `IDX_W`=3, `NUM_IDX`=6.
  - Player state enum (IDLE, SEND, GAP, FIN).
  - mode→count constants.
- Sub-module `rise_detect` (clk, rst, d → pulse), reusable for the scrambler's `RNG_gen`.
- Everything else is a single module: buffer, counters, FSM.

## Test plan
- Reset: hold `rst` 3 cycles with `done`=1 → all outputs 0. After release, one start is seen (edge from `done_q`=0) only if `done` is still high.
- Mode 00, indices 1..6, ready high, `GAP_CYCLES`=4 → `idx_out` 1,2,3,4 at `pos` 0..3, transfers 5 cycles apart, one `seq_done` pulse, `busy` then low.
- Mode 10, `GAP_CYCLES`=0, ready high → six back-to-back transfers 1..6, then `seq_done`.
- Backpressure: ready low for 7 cycles on item 2 → `idx_out`=2 and `pos`=1 held stable, no duplicate or lost item.
- Second `done` edge during playback with different indices → ignored; the original sequence completes. A new edge after IDLE plays the new values.
- `rst` mid-GAP → outputs 0 next cycle, nothing emitted afterwards. With macro: `replay` pulse after completion → same 4/5/6 items replayed; `replay` before any load → no activity.
